// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types: FSM state enum, data width, holding-register frame
// Optional macro: UART_RX_BREAK_EN adds the BRK_WAIT state.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
`ifdef UART_RX_BREAK_EN
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
`else
        STOP     = 3'd4
`endif
    } rx_state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 parity_error;
        logic                 framing_error;
        logic                 break_detect;
    } rx_frame_t;

endpackage

// File: rtl/parity_checker.sv
// rtl/parity_checker.sv - combinational parity check of a received byte against its parity bit
// Ports: rsr_data (received byte), received_parity (sampled parity bit),
//        pen/eps/sp (parity enable, even select, stick parity), parity_error (1 = mismatch).
// Stick parity forces the expected bit to ~eps; otherwise even/odd parity over rsr_data.
module parity_checker
    import uart_pkg::*;
(
    input  logic [DATA_BITS-1:0] rsr_data,
    input  logic                 received_parity,
    input  logic                 pen,
    input  logic                 eps,
    input  logic                 sp,
    output logic                 parity_error
);

    logic expected_bit;

    always_comb begin
        expected_bit = 1'b0;
        if (sp) begin
            expected_bit = ~eps;
        end else if (eps) begin
            expected_bit = ^rsr_data;
        end else begin
            expected_bit = ~^rsr_data;
        end
        parity_error = pen & (received_parity != expected_bit);
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer with oversampling FSM and single-entry holding register
// Ports: clk, rst_n (async active-low), baud_tick (OVERSAMPLE x baud strobe), rxd (async serial in),
//        pen/eps/sp (parity config, latched at start confirm), rx_ready (consumer accept),
//        rx_data/rx_valid/parity_error/framing_error/break_detect (holding register),
//        overrun_error (one-cycle pulse on a dropped frame).
// Optional macro: UART_RX_BREAK_EN enables break detection and the BRK_WAIT state.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rxd,
    input  logic                 pen,
    input  logic                 eps,
    input  logic                 sp,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 break_detect
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                 sync1, rxs;
    rx_state_t            state;
    logic [CW-1:0]        samp_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] rsr;
    logic                 received_parity;
    logic                 pen_q, eps_q, sp_q;
    logic                 chk_parity_error;
    logic                 is_break;
    logic                 stop_done;
    rx_frame_t            hold;
    logic                 valid_q;
    logic                 overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    parity_checker u_parity_checker (
        .rsr_data        (rsr),
        .received_parity (received_parity),
        .pen             (pen_q),
        .eps             (eps_q),
        .sp              (sp_q),
        .parity_error    (chk_parity_error)
    );

    // A break is an all-zero frame: data, parity (when present) and stop all low.
`ifdef UART_RX_BREAK_EN
    assign is_break = (rsr == '0) && !(pen_q && received_parity) && !rxs;
`else
    assign is_break = 1'b0;
`endif

    assign stop_done = (state == STOP) && baud_tick && (samp_cnt == FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            samp_cnt        <= '0;
            bit_cnt         <= '0;
            rsr             <= '0;
            received_parity <= 1'b0;
            pen_q           <= 1'b0;
            eps_q           <= 1'b0;
            sp_q            <= 1'b0;
        end else if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        samp_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (samp_cnt == HALF_CNT) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            pen_q    <= pen;
                            eps_q    <= eps;
                            sp_q     <= sp;
                            samp_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                        end
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (samp_cnt == FULL_CNT) begin
                        samp_cnt <= '0;
                        rsr      <= {rxs, rsr[DATA_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= pen_q ? PARITY : STOP;
                        end
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (samp_cnt == FULL_CNT) begin
                        samp_cnt        <= '0;
                        received_parity <= rxs;
                        state           <= STOP;
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (samp_cnt == FULL_CNT) begin
                        samp_cnt <= '0;
`ifdef UART_RX_BREAK_EN
                        state    <= is_break ? BRK_WAIT : IDLE;
`else
                        state    <= IDLE;
`endif
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_EN
                BRK_WAIT: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: a completing frame wins over a same-cycle read, which
    // frees the slot for it; a full slot with no read drops the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (stop_done) begin
                if (!valid_q || rx_ready) begin
                    hold.data          <= rsr;
                    hold.parity_error  <= chk_parity_error;
                    hold.framing_error <= ~rxs;
                    hold.break_detect  <= is_break;
                    valid_q            <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_ready && valid_q) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data       = hold.data;
    assign parity_error  = hold.parity_error;
    assign framing_error = hold.framing_error;
    assign break_detect  = hold.break_detect;
    assign rx_valid      = valid_q;
    assign overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a frame-level reference model
module tb_uart_rx_ctrl;

    localparam int OS      = 16;
    localparam int BIT_CLK = OS * 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rxd = 1'b1;
    logic       pen = 1'b0, eps = 1'b0, sp = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_error, framing_error, overrun_error, break_detect;

    int pass_cnt = 0;
    int check_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int rise_count = 0;
    int ovr_count = 0;
    logic valid_d = 1'b0;
    logic [10:0] got_q[$];

    uart_rx_ctrl #(.OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_tick     (baud_tick),
        .rxd           (rxd),
        .pen           (pen),
        .eps           (eps),
        .sp            (sp),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .break_detect  (break_detect)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        cyc++;
        baud_tick = (cyc % 4 == 0);
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (overrun_error) ovr_count++;
        if (rx_valid && !valid_d) begin
            rise_count++;
            rise_cyc = cyc;
        end
        valid_d = rx_valid;
        if (rx_valid && rx_ready) got_q.push_back({parity_error, framing_error, break_detect, rx_data});
    end

    // Expected {parity_error, framing_error, break_detect, data} from the frame as sent on the wire.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic p_en, input logic p_eps,
                                                input logic p_sp, input logic pbit, input logic stop);
        logic pe, fe, brk;
        int   ones;
        ones = $countones(d) + int'(pbit);
        if (!p_en)      pe = 1'b0;
        else if (p_sp)  pe = (pbit != !p_eps);
        else if (p_eps) pe = (ones % 2 != 0);
        else            pe = (ones % 2 != 1);
        fe = !stop;
`ifdef UART_RX_BREAK_EN
        brk = (d == 8'h00) && (!p_en || !pbit) && !stop;
`else
        brk = 1'b0;
`endif
        return {pe, fe, brk, d};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pbit,
                              input logic stop, input logic scramble);
        @(negedge clk);
        rxd = 1'b0;
        #1;
        start_cyc = cyc;
        repeat (BIT_CLK) @(negedge clk);
        if (scramble) begin
            pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (use_par) begin
            rxd = pbit;
            repeat (BIT_CLK) @(negedge clk);
        end
        rxd = stop;
        repeat (BIT_CLK) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 400 && !rx_valid; i++) @(negedge clk);
        #1;
    endtask

    task automatic consume();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_cnt++;
        if ({rx_valid, rx_data, parity_error, framing_error, overrun_error, break_detect} !== 13'h0)
            $display("FAIL reset_outputs got %h required 0",
                     {rx_valid, rx_data, parity_error, framing_error, overrun_error, break_detect});
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL idle_valid got %b required 0", rx_valid);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [11:0] exp;
        int lat;
        pen = 1'b0; eps = 1'b0; sp = 1'b0;
        exp = {1'b1, model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid();
        check_cnt++;
        if ({rx_valid, parity_error, framing_error, break_detect, rx_data} !== exp)
            $display("FAIL basic_a5 got %h required %h",
                     {rx_valid, parity_error, framing_error, break_detect, rx_data}, exp);
        else pass_cnt++;
        lat = rise_cyc - start_cyc;
        check_cnt++;
        if (lat < 606 || lat > 614) $display("FAIL basic_latency got %0d required 606..614", lat);
        else pass_cnt++;
        consume();
        check_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL basic_consume got %b required 0", rx_valid);
        else pass_cnt++;
    endtask

    task automatic test_parity();
        logic [2:0]  cases [4] = '{3'b100, 3'b101, 3'b110, 3'b111};  // {eps, sp, parity bit}
        logic        req_pe[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [11:0] exp;
        for (int i = 0; i < 4; i++) begin
            pen = 1'b1; eps = cases[i][2]; sp = cases[i][1];
            exp = {1'b1, model_frame(8'h3C, 1'b1, cases[i][2], cases[i][1], cases[i][0], 1'b1)};
            send_frame(8'h3C, 1'b1, cases[i][0], 1'b1, 1'b0);
            wait_valid();
            check_cnt++;
            if ({rx_valid, parity_error, framing_error, break_detect, rx_data} !== exp)
                $display("FAIL parity_case%0d got %h required %h", i,
                         {rx_valid, parity_error, framing_error, break_detect, rx_data}, exp);
            else pass_cnt++;
            check_cnt++;
            if (parity_error !== req_pe[i])
                $display("FAIL parity_flag%0d got %b required %b", i, parity_error, req_pe[i]);
            else pass_cnt++;
            consume();
        end
        pen = 1'b0; eps = 1'b0; sp = 1'b0;
    endtask

    task automatic test_framing();
        logic [11:0] exp;
        exp = {1'b1, model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_valid();
        check_cnt++;
        if ({rx_valid, parity_error, framing_error, break_detect, rx_data} !== exp)
            $display("FAIL framing_55 got %h required %h",
                     {rx_valid, parity_error, framing_error, break_detect, rx_data}, exp);
        else pass_cnt++;
        consume();
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_overrun();
        int ovr0;
        ovr0 = ovr_count;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        #1;
        check_cnt++;
        if (ovr_count - ovr0 != 1) $display("FAIL overrun_pulses got %0d required 1", ovr_count - ovr0);
        else pass_cnt++;
        check_cnt++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h11})
            $display("FAIL overrun_keep got %h required %h", {rx_valid, rx_data}, {1'b1, 8'h11});
        else pass_cnt++;
        consume();
        check_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL overrun_clear got %b required 0", rx_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d[3];
        logic [10:0] exp_q[$];
        int          ovr0;
        ovr0 = ovr_count;
        got_q.delete();
        pen = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'($urandom);
            exp_q.push_back(model_frame(d[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            send_frame(d[i], 1'b0, 1'b0, 1'b1, 1'b0);
        end
        repeat (100) @(negedge clk);
        rx_ready = 1'b0;
        #1;
        check_cnt++;
        if (got_q.size() != 3 || ovr_count != ovr0)
            $display("FAIL b2b_count got %0d frames %0d overruns required 3 frames 0 overruns",
                     got_q.size(), ovr_count - ovr0);
        else pass_cnt++;
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            check_cnt++;
            if (got_q[i] !== exp_q[i]) $display("FAIL b2b_frame%0d got %h required %h", i, got_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        int rise0;
        rise0 = rise_count;
        @(negedge clk);
        rxd = 1'b0;
        repeat (24) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        #1;
        check_cnt++;
        if (rx_valid !== 1'b0 || rise_count != rise0)
            $display("FAIL glitch got valid %b frames %0d required valid 0 frames 0", rx_valid, rise_count - rise0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic        p_en, p_eps, p_sp, pbit, stop;
        logic [11:0] exp;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            if (i == 7) d = 8'h00;
            p_en = 1'($urandom); p_eps = 1'($urandom); p_sp = 1'($urandom);
            pbit = 1'($urandom); stop = ($urandom_range(3) != 0);
            pen = p_en; eps = p_eps; sp = p_sp;
            exp = {1'b1, model_frame(d, p_en, p_eps, p_sp, pbit, stop)};
            send_frame(d, p_en, pbit, stop, 1'b1);
            wait_valid();
            check_cnt++;
            if ({rx_valid, parity_error, framing_error, break_detect, rx_data} !== exp)
                $display("FAIL random%0d got %h required %h (pen %b eps %b sp %b pbit %b stop %b)", i,
                         {rx_valid, parity_error, framing_error, break_detect, rx_data}, exp,
                         p_en, p_eps, p_sp, pbit, stop);
            else pass_cnt++;
            consume();
            repeat (BIT_CLK) @(negedge clk);
        end
        pen = 1'b0; eps = 1'b0; sp = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid();
        check_cnt++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h5A})
            $display("FAIL pre_reset got %h required %h", {rx_valid, rx_data}, {1'b1, 8'h5A});
        else pass_cnt++;
        fork
            send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (4 * BIT_CLK) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                check_cnt++;
                if ({rx_valid, rx_data, parity_error, framing_error, overrun_error, break_detect} !== 13'h0)
                    $display("FAIL reset_mid got %h required 0",
                             {rx_valid, rx_data, parity_error, framing_error, overrun_error, break_detect});
                else pass_cnt++;
            end
        join
        rst_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        exp = {1'b1, model_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid();
        check_cnt++;
        if ({rx_valid, parity_error, framing_error, break_detect, rx_data} !== exp)
            $display("FAIL after_reset got %h required %h",
                     {rx_valid, parity_error, framing_error, break_detect, rx_data}, exp);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_break();
        int          rise0, ovr0;
        logic [11:0] exp;
        pen = 1'b0;
`ifdef UART_RX_BREAK_EN
        rise0 = rise_count;
        ovr0  = ovr_count;
        @(negedge clk);
        rxd = 1'b0;
        repeat (30 * BIT_CLK) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * BIT_CLK) @(negedge clk);
        #1;
        check_cnt++;
        if (rise_count - rise0 != 1 || ovr_count != ovr0)
            $display("FAIL break_count got %0d frames %0d overruns required 1 frame 0 overruns",
                     rise_count - rise0, ovr_count - ovr0);
        else pass_cnt++;
        check_cnt++;
        if ({rx_valid, parity_error, framing_error, break_detect, rx_data} !== {4'b1011, 8'h00})
            $display("FAIL break_frame got %h required %h",
                     {rx_valid, parity_error, framing_error, break_detect, rx_data}, {4'b1011, 8'h00});
        else pass_cnt++;
        consume();
        exp = {1'b1, model_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid();
        check_cnt++;
        if ({rx_valid, parity_error, framing_error, break_detect, rx_data} !== exp)
            $display("FAIL break_recover got %h required %h",
                     {rx_valid, parity_error, framing_error, break_detect, rx_data}, exp);
        else pass_cnt++;
        consume();
`else
        rise0 = 0; ovr0 = 0; exp = '0;
        got_q.delete();
        rx_ready = 1'b1;
        @(negedge clk);
        rxd = 1'b0;
        repeat (30 * BIT_CLK) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * BIT_CLK) @(negedge clk);
        rx_ready = 1'b0;
        #1;
        check_cnt++;
        if (got_q.size() < 2) $display("FAIL held_low_count got %0d required >=2", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            check_cnt++;
            if (got_q[i] !== {3'b010, 8'h00})
                $display("FAIL held_low_frame%0d got %h required %h", i, got_q[i], {3'b010, 8'h00});
            else pass_cnt++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_glitch();
        test_random();
        test_reset_mid();
        test_break();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
